// File: rtl/cpu_axi_bridge.sv
// Bridges the core's sram-like inst/data ports onto a single AXI-style master
// with one transaction outstanding and fixed-priority arbitration.
module cpu_axi_bridge #(
    parameter bit DATA_PRIO = 1'b1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic [31:0] araddr,
    output logic [2:0]  arsize,
    output logic        arvalid,
    input  logic        arready,
    input  logic [31:0] rdata,
    input  logic        rvalid,
    output logic        rready,
    output logic [31:0] awaddr,
    output logic [2:0]  awsize,
    output logic        awvalid,
    input  logic        awready,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wvalid,
    input  logic        wready,
    input  logic        bvalid,
    output logic        bready
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_AR   = 3'd1,
        S_R    = 3'd2,
        S_W    = 3'd3,
        S_B    = 3'd4
    } state_t;

    // Size code 3 is not a legal core request; treat it as a word access.
    function automatic logic [1:0] norm_size(input logic [1:0] sz);
        norm_size = (sz == 2'd3) ? 2'd2 : sz;
    endfunction

    state_t      r_state;
    state_t      w_next_state;
    logic        r_owner;
    logic [31:0] r_addr;
    logic [1:0]  r_size;
    logic [3:0]  r_wstrb;
    logic [31:0] r_wdata;
    logic        r_aw_done;
    logic        r_w_done;
    logic        w_aw_done_nxt;
    logic        w_w_done_nxt;
    logic        w_grant_data;
    logic        w_grant_inst;
    logic        w_accept_data;
    logic        w_accept_inst;
    logic        w_aw_hs;
    logic        w_w_hs;
    logic        w_rd_done;

    assign w_grant_data  = data_req && (!inst_req || DATA_PRIO);
    assign w_grant_inst  = inst_req && !w_grant_data;
    // Gated by resetn so no request is acknowledged while reset is asserted.
    assign w_accept_data = resetn && (r_state == S_IDLE) && w_grant_data;
    assign w_accept_inst = resetn && (r_state == S_IDLE) && w_grant_inst;

    assign w_aw_hs   = awvalid && awready;
    assign w_w_hs    = wvalid && wready;
    assign w_rd_done = (r_state == S_R) && rvalid;

    assign inst_addr_ok = w_accept_inst;
    assign data_addr_ok = w_accept_data;
    assign inst_data_ok = w_rd_done && !r_owner;
    assign inst_rdata   = inst_data_ok ? rdata : 32'h0000_0000;
    assign data_data_ok = (w_rd_done && r_owner) || ((r_state == S_B) && bvalid);
    assign data_rdata   = (w_rd_done && r_owner) ? rdata : 32'h0000_0000;

    assign araddr  = r_addr;
    assign arsize  = {1'b0, r_size};
    assign arvalid = (r_state == S_AR);
    assign rready  = (r_state == S_R);
    assign awaddr  = r_addr;
    assign awsize  = {1'b0, r_size};
    assign awvalid = (r_state == S_W) && !r_aw_done;
    assign wdata   = r_wdata;
    assign wstrb   = r_wstrb;
    assign wvalid  = (r_state == S_W) && !r_w_done;
    assign bready  = (r_state == S_B);

    // State, handshake flags and request fields captured at acceptance.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state   <= S_IDLE;
            r_owner   <= 1'b0;
            r_addr    <= 32'h0000_0000;
            r_size    <= 2'd0;
            r_wstrb   <= 4'h0;
            r_wdata   <= 32'h0000_0000;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_aw_done <= w_aw_done_nxt;
            r_w_done  <= w_w_done_nxt;
            if (w_accept_data) begin
                r_owner <= 1'b1;
                r_addr  <= data_addr;
                r_size  <= norm_size(data_size);
                r_wstrb <= data_wstrb;
                r_wdata <= data_wdata;
            end else if (w_accept_inst) begin
                r_owner <= 1'b0;
                r_addr  <= inst_addr;
                r_size  <= 2'd2;
                r_wstrb <= 4'h0;
                r_wdata <= 32'h0000_0000;
            end
        end
    end

    // Next-state and write-handshake bookkeeping.
    always_comb begin
        w_next_state  = r_state;
        w_aw_done_nxt = r_aw_done;
        w_w_done_nxt  = r_w_done;
        case (r_state)
            S_IDLE: begin
                if (w_accept_data) begin
                    w_next_state = data_wr ? S_W : S_AR;
                end else if (w_accept_inst) begin
                    w_next_state = S_AR;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_AR: begin
                if (arready) begin
                    w_next_state = S_R;
                end else begin
                    w_next_state = S_AR;
                end
            end
            S_R: begin
                if (rvalid) begin
                    w_next_state = S_IDLE;
                end else begin
                    w_next_state = S_R;
                end
            end
            S_W: begin
                // Address and data channels complete independently, in any order.
                if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs)) begin
                    w_next_state  = S_B;
                    w_aw_done_nxt = 1'b0;
                    w_w_done_nxt  = 1'b0;
                end else begin
                    w_next_state  = S_W;
                    w_aw_done_nxt = r_aw_done || w_aw_hs;
                    w_w_done_nxt  = r_w_done || w_w_hs;
                end
            end
            S_B: begin
                if (bvalid) begin
                    w_next_state = S_IDLE;
                end else begin
                    w_next_state = S_B;
                end
            end
            default: begin
                w_next_state  = S_IDLE;
                w_aw_done_nxt = 1'b0;
                w_w_done_nxt  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_cpu_axi_bridge.sv
// Directed bench for cpu_axi_bridge; the bench plays the AXI slave by hand.
module tb_cpu_axi_bridge;

    logic        clk = 1'b0;
    logic        resetn;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok, inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr, data_wdata;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic [31:0] araddr;
    logic [2:0]  arsize;
    logic        arvalid, arready;
    logic [31:0] rdata;
    logic        rvalid, rready;
    logic [31:0] awaddr;
    logic [2:0]  awsize;
    logic        awvalid, awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid, wready, bvalid, bready;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    cpu_axi_bridge #(.DATA_PRIO(1'b1)) dut (
        .clk(clk), .resetn(resetn),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
        .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_wstrb(data_wstrb), .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .araddr(araddr), .arsize(arsize), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awsize(awsize), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bvalid(bvalid), .bready(bready)
    );

    // Advance to just after the next rising edge; checks follow a 1-unit settle.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        resetn = 1'b0; inst_req = 1'b0; inst_addr = 32'h0; data_req = 1'b0; data_wr = 1'b0;
        data_size = 2'd0; data_wstrb = 4'h0; data_addr = 32'h0; data_wdata = 32'h0;
        arready = 1'b0; rdata = 32'h0; rvalid = 1'b0; awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
        #2;
        n_cmp++; if ({arvalid, awvalid, wvalid, rready, bready} !== 5'b00000) begin n_fail++; $display("FAIL rst_valids got %b want 00000", {arvalid, awvalid, wvalid, rready, bready}); end
        n_cmp++; if ({inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok} !== 4'b0000) begin n_fail++; $display("FAIL rst_oks got %b want 0000", {inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}); end
        n_cmp++; if ({araddr, awaddr, wdata} !== 96'h0) begin n_fail++; $display("FAIL rst_addr got %h want 0", {araddr, awaddr, wdata}); end
        step(); step();
        resetn = 1'b1;
    endtask

    task automatic test_inst_read();
        inst_req = 1'b1; inst_addr = 32'h1C00_0000; #1;
        n_cmp++; if ({inst_addr_ok, data_addr_ok, arvalid} !== 3'b100) begin n_fail++; $display("FAIL ird_t0 got %b want 100", {inst_addr_ok, data_addr_ok, arvalid}); end
        step(); inst_req = 1'b0; inst_addr = 32'h0; arready = 1'b1; #1;
        n_cmp++; if (arvalid !== 1'b1) begin n_fail++; $display("FAIL ird_arvalid got %b want 1", arvalid); end
        n_cmp++; if (araddr !== 32'h1C00_0000) begin n_fail++; $display("FAIL ird_araddr got %h want 1c000000", araddr); end
        n_cmp++; if (arsize !== 3'd2) begin n_fail++; $display("FAIL ird_arsize got %0d want 2", arsize); end
        step(); arready = 1'b0; rvalid = 1'b1; rdata = 32'h0280_0C0C; #1;
        n_cmp++; if ({rready, inst_data_ok, data_data_ok} !== 3'b110) begin n_fail++; $display("FAIL ird_t2 got %b want 110", {rready, inst_data_ok, data_data_ok}); end
        n_cmp++; if (inst_rdata !== 32'h0280_0C0C) begin n_fail++; $display("FAIL ird_rdata got %h want 02800c0c", inst_rdata); end
        step(); rvalid = 1'b0; #1;
        n_cmp++; if ({inst_data_ok, rready, arvalid} !== 3'b000) begin n_fail++; $display("FAIL ird_done got %b want 000", {inst_data_ok, rready, arvalid}); end
    endtask

    task automatic test_priority();
        inst_req = 1'b1; inst_addr = 32'h0000_0100;
        data_req = 1'b1; data_wr = 1'b0; data_size = 2'd0; data_addr = 32'h0000_2000; #1;
        n_cmp++; if ({data_addr_ok, inst_addr_ok} !== 2'b10) begin n_fail++; $display("FAIL pri_grant got %b want 10", {data_addr_ok, inst_addr_ok}); end
        step(); data_req = 1'b0; arready = 1'b1; #1;
        n_cmp++; if ({araddr, arsize} !== {32'h0000_2000, 3'd0}) begin n_fail++; $display("FAIL pri_ar got %h/%0d want 2000/0", araddr, arsize); end
        n_cmp++; if (inst_addr_ok !== 1'b0) begin n_fail++; $display("FAIL pri_inst_wait got %b want 0", inst_addr_ok); end
        step(); arready = 1'b0; rvalid = 1'b1; rdata = 32'h0000_0055; #1;
        n_cmp++; if ({data_data_ok, inst_data_ok, inst_addr_ok} !== 3'b100) begin n_fail++; $display("FAIL pri_dok got %b want 100", {data_data_ok, inst_data_ok, inst_addr_ok}); end
        n_cmp++; if (data_rdata !== 32'h0000_0055) begin n_fail++; $display("FAIL pri_rdata got %h want 55", data_rdata); end
        step(); rvalid = 1'b0; #1;
        n_cmp++; if (inst_addr_ok !== 1'b1) begin n_fail++; $display("FAIL pri_inst_next got %b want 1", inst_addr_ok); end
        step(); inst_req = 1'b0; arready = 1'b1; #1;
        n_cmp++; if ({araddr, arsize} !== {32'h0000_0100, 3'd2}) begin n_fail++; $display("FAIL pri_ar2 got %h/%0d want 100/2", araddr, arsize); end
        step(); arready = 1'b0; rvalid = 1'b1; rdata = 32'h1234_5678; #1;
        n_cmp++; if ({inst_data_ok, inst_rdata} !== {1'b1, 32'h1234_5678}) begin n_fail++; $display("FAIL pri_inst_dok got %b/%h want 1/12345678", inst_data_ok, inst_rdata); end
        step(); rvalid = 1'b0;
    endtask

    task automatic test_write();
        data_req = 1'b1; data_wr = 1'b1; data_size = 2'd2; data_addr = 32'h0000_0080;
        data_wdata = 32'hDEAD_BEEF; data_wstrb = 4'hF; #1;
        n_cmp++; if ({data_addr_ok, arvalid, awvalid} !== 3'b100) begin n_fail++; $display("FAIL wr_t0 got %b want 100", {data_addr_ok, arvalid, awvalid}); end
        step(); data_req = 1'b0; data_wdata = 32'h0; data_wstrb = 4'h0; wready = 1'b1; awready = 1'b0; #1;
        n_cmp++; if ({awvalid, wvalid, bready} !== 3'b110) begin n_fail++; $display("FAIL wr_t1 got %b want 110", {awvalid, wvalid, bready}); end
        n_cmp++; if ({awaddr, awsize, wdata, wstrb} !== {32'h0000_0080, 3'd2, 32'hDEAD_BEEF, 4'hF}) begin n_fail++; $display("FAIL wr_fields got %h %0d %h %h want 80 2 deadbeef f", awaddr, awsize, wdata, wstrb); end
        step(); wready = 1'b0; #1;
        n_cmp++; if ({awvalid, wvalid, bready} !== 3'b100) begin n_fail++; $display("FAIL wr_t2 got %b want 100", {awvalid, wvalid, bready}); end
        step(); awready = 1'b1; #1;
        n_cmp++; if ({awvalid, wvalid, bready} !== 3'b100) begin n_fail++; $display("FAIL wr_t3 got %b want 100", {awvalid, wvalid, bready}); end
        step(); awready = 1'b0; #1;
        n_cmp++; if ({awvalid, wvalid, bready, data_data_ok} !== 4'b0010) begin n_fail++; $display("FAIL wr_b got %b want 0010", {awvalid, wvalid, bready, data_data_ok}); end
        step(); bvalid = 1'b1; #1;
        n_cmp++; if ({bready, data_data_ok, inst_data_ok} !== 3'b110) begin n_fail++; $display("FAIL wr_dok got %b want 110", {bready, data_data_ok, inst_data_ok}); end
        step(); bvalid = 1'b0; #1;
        n_cmp++; if ({bready, data_data_ok} !== 2'b00) begin n_fail++; $display("FAIL wr_idle got %b want 00", {bready, data_data_ok}); end
    endtask

    task automatic test_ar_backpressure();
        data_req = 1'b1; data_wr = 1'b0; data_size = 2'd3; data_addr = 32'h0000_3004; #1;
        n_cmp++; if (data_addr_ok !== 1'b1) begin n_fail++; $display("FAIL bp_aok got %b want 1", data_addr_ok); end
        step(); data_addr = 32'hFFFF_0000; data_size = 2'd1; arready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            n_cmp++; if ({arvalid, araddr, arsize, data_addr_ok} !== {1'b1, 32'h0000_3004, 3'd2, 1'b0}) begin n_fail++; $display("FAIL bp_hold%0d got %b %h %0d %b want 1 3004 2 0", i, arvalid, araddr, arsize, data_addr_ok); end
            step();
        end
        arready = 1'b1;
        step(); arready = 1'b0; rvalid = 1'b1; rdata = 32'hCAFE_0001; #1;
        n_cmp++; if ({data_data_ok, data_rdata} !== {1'b1, 32'hCAFE_0001}) begin n_fail++; $display("FAIL bp_dok got %b/%h want 1/cafe0001", data_data_ok, data_rdata); end
        step(); rvalid = 1'b0; #1;
        n_cmp++; if (data_addr_ok !== 1'b1) begin n_fail++; $display("FAIL b2b_aok got %b want 1", data_addr_ok); end
        step(); data_req = 1'b0; arready = 1'b1; #1;
        n_cmp++; if ({araddr, arsize} !== {32'hFFFF_0000, 3'd1}) begin n_fail++; $display("FAIL b2b_ar got %h/%0d want ffff0000/1", araddr, arsize); end
        step(); arready = 1'b0; rvalid = 1'b1; rdata = 32'h0000_00AA; #1;
        n_cmp++; if (data_data_ok !== 1'b1) begin n_fail++; $display("FAIL b2b_dok got %b want 1", data_data_ok); end
        step(); rvalid = 1'b0;
    endtask

    task automatic test_early_resp();
        inst_req = 1'b1; inst_addr = 32'h0000_0040; #1;
        n_cmp++; if (inst_addr_ok !== 1'b1) begin n_fail++; $display("FAIL early_aok got %b want 1", inst_addr_ok); end
        step(); inst_req = 1'b0; arready = 1'b0; bvalid = 1'b1; rvalid = 1'b1; rdata = 32'h0000_0077;
        for (int i = 0; i < 2; i++) begin
            #1;
            n_cmp++; if ({arvalid, rready, bready, inst_data_ok, data_data_ok} !== 5'b10000) begin n_fail++; $display("FAIL early_ar%0d got %b want 10000", i, {arvalid, rready, bready, inst_data_ok, data_data_ok}); end
            step();
        end
        bvalid = 1'b0; arready = 1'b1;
        step(); arready = 1'b0; #1;
        n_cmp++; if ({rready, inst_data_ok, inst_rdata} !== {2'b11, 32'h0000_0077}) begin n_fail++; $display("FAIL early_r got %b %b %h want 1 1 77", rready, inst_data_ok, inst_rdata); end
        step(); rvalid = 1'b0; #1;
        n_cmp++; if ({rready, inst_data_ok} !== 2'b00) begin n_fail++; $display("FAIL early_done got %b want 00", {rready, inst_data_ok}); end
    endtask

    task automatic test_reset_mid();
        data_req = 1'b1; data_wr = 1'b1; data_size = 2'd2; data_addr = 32'h0000_0090;
        data_wdata = 32'h1111_2222; data_wstrb = 4'h3;
        step(); inst_req = 1'b1; inst_addr = 32'h0000_0500; awready = 1'b0; wready = 1'b0; #1;
        n_cmp++; if ({awvalid, wvalid} !== 2'b11) begin n_fail++; $display("FAIL rmid_w got %b want 11", {awvalid, wvalid}); end
        #1; resetn = 1'b0; #1;
        n_cmp++; if ({awvalid, wvalid, inst_addr_ok, data_addr_ok} !== 4'b0000) begin n_fail++; $display("FAIL rmid_drop got %b want 0000", {awvalid, wvalid, inst_addr_ok, data_addr_ok}); end
        n_cmp++; if ({data_data_ok, bready} !== 2'b00) begin n_fail++; $display("FAIL rmid_nodok got %b want 00", {data_data_ok, bready}); end
        step(); resetn = 1'b1; data_req = 1'b0; #1;
        n_cmp++; if ({inst_addr_ok, awvalid, arvalid} !== 3'b100) begin n_fail++; $display("FAIL rmid_fresh got %b want 100", {inst_addr_ok, awvalid, arvalid}); end
        step(); inst_req = 1'b0; arready = 1'b1; #1;
        n_cmp++; if ({arvalid, araddr} !== {1'b1, 32'h0000_0500}) begin n_fail++; $display("FAIL rmid_ar got %b/%h want 1/500", arvalid, araddr); end
        step(); arready = 1'b0; rvalid = 1'b1; rdata = 32'h0BAD_F00D; #1;
        n_cmp++; if ({inst_data_ok, inst_rdata} !== {1'b1, 32'h0BAD_F00D}) begin n_fail++; $display("FAIL rmid_dok got %b/%h want 1/0badf00d", inst_data_ok, inst_rdata); end
        step(); rvalid = 1'b0;
    endtask

    initial begin
        test_reset();
        step();
        test_inst_read();
        test_priority();
        test_write();
        test_ar_backpressure();
        test_early_resp();
        test_reset_mid();
        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/cpu_axi_bridge.md
Name: cpu_axi_bridge

Overview:
Sits directly downstream of the CPU core's instruction and data memory ports. It converts two sram-like request/addr_ok/data_ok channels (inst read-only, data read/write) into one AXI-style master interface with one transaction outstanding. Arbitration between the channels is fixed-priority. The core uses this block to reach off-core memory in place of zero-wait SRAM.

Parameters:
DATA_PRIO, 1, 1: data channel wins when inst and data request in the same cycle; 0: inst wins

Ports:
clk  input  1  clock, all state updates on posedge
resetn  input  1  asynchronous active-low reset
inst_req  input  1  inst read request, held until inst_addr_ok
inst_addr  input  32  inst fetch address, word aligned
inst_addr_ok  output  1  inst request accepted this cycle
inst_data_ok  output  1  inst read data valid this cycle (1-cycle pulse)
inst_rdata  output  32  inst read data, meaningful only with inst_data_ok
data_req  input  1  data request, held until data_addr_ok
data_wr  input  1  1 = write, 0 = read
data_size  input  2  0 byte, 1 half, 2 word; 3 treated as 2
data_wstrb  input  4  byte strobes for writes
data_addr  input  32  data address
data_wdata  input  32  write data
data_addr_ok  output  1  data request accepted this cycle
data_data_ok  output  1  read data valid / write complete (1-cycle pulse)
data_rdata  output  32  read data, meaningful only with data_data_ok on a read
araddr  output  32  AXI read address
arsize  output  3  AXI read size
arvalid  output  1  AXI read address valid
arready  input  1  AXI read address ready
rdata  input  32  AXI read data
rvalid  input  1  AXI read data valid
rready  output  1  AXI read data ready
awaddr  output  32  AXI write address
awsize  output  3  AXI write size
awvalid  output  1  AXI write address valid
awready  input  1  AXI write address ready
wdata  output  32  AXI write data
wstrb  output  4  AXI write strobes
wvalid  output  1  AXI write data valid
wready  input  1  AXI write data ready
bvalid  input  1  AXI write response valid
bready  output  1  AXI write response ready

Behaviour:
- FSM states: IDLE, AR, R, W, B. Registers: owner (inst/data), addr, size, wstrb, wdata, aw_done, w_done.
- Reset (resetn=0, async): state=IDLE, owner=inst, aw_done=w_done=0. All valid/ready/ok outputs are 0; address/data outputs are 0.
- IDLE: grant = the pending channel. If both channels are pending, the channel selected by DATA_PRIO wins. The granted channel's addr_ok=1 combinationally in that cycle; the other channel's addr_ok=0 and it must hold req. At the edge, latch the request fields. Next state is AR for any inst request or a data read, and W for a data write.
- addr_ok is asserted only in IDLE. A new request is not accepted while a transaction is outstanding.
- AR: arvalid=1, araddr=latched addr. arsize={1'b0,size} for data, 3'd2 for inst. On arready, go to R.
- R: rready=1. When rvalid=1, pulse the owner's data_ok and drive the owner's rdata=rdata combinationally. Go to IDLE.
- W: awvalid=!aw_done and wvalid=!w_done. awaddr, awsize, wdata and wstrb come from the latched fields. Set aw_done on awvalid&awready and w_done on wvalid&wready; the two handshakes may complete in either order or in the same cycle. Once both are done (counting this cycle's handshakes), clear both flags and go to B.
- B: bready=1. When bvalid=1, pulse data_data_ok (data_rdata don't-care) and go to IDLE.
- rready=0 outside R and bready=0 outside B. Early rvalid/bvalid is not consumed.
- Back-to-back: a request held across a data_ok cycle gets addr_ok in the next cycle (IDLE). Minimum read round trip with zero-wait slave: addr_ok at T, arvalid T+1, data_ok T+2.
- The latched fields are stable from addr_ok until data_ok; later changes on request inputs have no effect.
- Reset mid-transaction: all AXI valids drop immediately and no data_ok is issued; the slave is reset alongside.

Test Plan:
- Single inst read: inst_req addr 0x1C000000, arready=1 immediately, rvalid next cycle rdata 0x02800C0C -> inst_addr_ok T0, arvalid/araddr 0x1C000000 arsize 2 at T1, inst_data_ok with inst_rdata 0x02800C0C at T2.
- Simultaneous requests, DATA_PRIO=1: inst addr 0x100 and data read addr 0x2000 size 0 -> data_addr_ok first, araddr 0x2000 arsize 0; inst_addr_ok only in the cycle after data_data_ok.
- Data write with awready delayed 3 cycles and wready immediate: addr 0x80, wdata 0xDEADBEEF, wstrb 0xF -> wvalid drops after 1 cycle, awvalid held 3 cycles, bready only after both handshakes, data_data_ok on bvalid.
- AR backpressure: arready low 5 cycles -> arvalid and araddr stable; request inputs changed after addr_ok do not alter araddr.
- Early bvalid/rvalid asserted while in AR -> not consumed (rready=0, bready=0); no spurious data_ok.
- Assert resetn=0 while in W with awvalid=1 -> awvalid, wvalid and both addr_ok outputs 0 immediately; after release, state IDLE and a fresh inst request is accepted.
